// File: rtl/cpu_pkg.sv
// Shared encodings for the pipeline: memory access sizes, write-back select and MEM FSM states.
package cpu_pkg;
    localparam logic [1:0] MEM_B  = 2'b00;
    localparam logic [1:0] MEM_H  = 2'b01;
    localparam logic [1:0] MEM_W  = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic {ST_IDLE, ST_ACCESS} mem_state_t;

    // Size 11 behaves as a word access.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            MEM_B:   return 1'b1;
            MEM_H:   return ~addr[0];
            default: return (addr == 2'b00);
        endcase
    endfunction
endpackage

// File: rtl/load_ext.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
// Purely combinational.
module load_ext
    import cpu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_addr, 3'b000} +: 8];
        w_half = i_rdata[{i_addr[1], 4'b0000} +: 16];
        case (i_size)
            MEM_B:   o_data = {{24{~i_uns & w_byte[7]}}, w_byte};
            MEM_H:   o_data = {{16{~i_uns & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, request/ack data-memory FSM, store lane placement,
// load extension and the MEM/WB register. Stalls upstream while an access is outstanding.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_c,
    input  logic [XLEN-1:0] ex_st_data,
    input  logic            ex_mem_rd,
    input  logic            ex_mem_wr,
    input  logic [1:0]      ex_mem_size,
    input  logic            ex_mem_uns,
    input  logic [4:0]      ex_rd,
    input  logic            ex_rf_we,
    input  logic [1:0]      ex_wb_sel,
    input  logic [XLEN-1:0] ex_pc4,
    output logic            dm_req,
    output logic            dm_we,
    output logic [XLEN-1:0] dm_addr,
    output logic [XLEN-1:0] dm_wdata,
    output logic [3:0]      dm_be,
    input  logic            dm_ack,
    input  logic [XLEN-1:0] dm_rdata,
    output logic            mem_stall,
    output logic [XLEN-1:0] mem_alu_c,
    output logic [4:0]      mem_rd,
    output logic            mem_rf_we,
    output logic            mem_misalign,
    output logic            wb_valid,
    output logic            wb_rf_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_wD
);
    logic            r_em_valid, r_em_mem_rd, r_em_mem_wr, r_em_mem_uns, r_em_rf_we;
    logic [XLEN-1:0] r_em_alu_c, r_em_st_data, r_em_pc4;
    logic [1:0]      r_em_mem_size, r_em_wb_sel;
    logic [4:0]      r_em_rd;
    mem_state_t      r_state, w_state_nxt;
    logic            r_wb_valid, r_wb_rf_we;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_wD;

    logic            w_memop, w_aligned, w_need, w_stall, w_wb_valid;
    logic [XLEN-1:0] w_load, w_wD;

    assign w_memop   = r_em_valid & (r_em_mem_rd | r_em_mem_wr);
    assign w_aligned = is_aligned(r_em_mem_size, r_em_alu_c[1:0]);
    assign w_need    = w_memop & w_aligned;
    // Ack releases the stall in the same cycle so the result and the next instruction move together.
    assign w_stall   = w_need & ~((r_state == ST_ACCESS) & dm_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_em_valid    <= 1'b0;
            r_em_alu_c    <= '0;
            r_em_st_data  <= '0;
            r_em_mem_rd   <= 1'b0;
            r_em_mem_wr   <= 1'b0;
            r_em_mem_size <= 2'b00;
            r_em_mem_uns  <= 1'b0;
            r_em_rd       <= 5'd0;
            r_em_rf_we    <= 1'b0;
            r_em_wb_sel   <= 2'b00;
            r_em_pc4      <= '0;
        end else if (!w_stall) begin
            r_em_valid    <= ex_valid;
            r_em_alu_c    <= ex_alu_c;
            r_em_st_data  <= ex_st_data;
            r_em_mem_rd   <= ex_mem_rd;
            r_em_mem_wr   <= ex_mem_wr;
            r_em_mem_size <= ex_mem_size;
            r_em_mem_uns  <= ex_mem_uns;
            r_em_rd       <= ex_rd;
            r_em_rf_we    <= ex_rf_we;
            r_em_wb_sel   <= ex_wb_sel;
            r_em_pc4      <= ex_pc4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_need) w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (dm_ack) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Lane placement is driven from the held EX/MEM register, so it stays stable for the request.
    always_comb begin
        dm_wdata = r_em_st_data;
        dm_be    = 4'b1111;
        if (r_em_mem_wr) begin
            case (r_em_mem_size)
                MEM_B: begin
                    dm_wdata = {4{r_em_st_data[7:0]}};
                    dm_be    = 4'b0001 << r_em_alu_c[1:0];
                end
                MEM_H: begin
                    dm_wdata = {2{r_em_st_data[15:0]}};
                    dm_be    = 4'b0011 << r_em_alu_c[1:0];
                end
                default: ;
            endcase
        end
    end

    load_ext u_load_ext (
        .i_rdata (dm_rdata),
        .i_addr  (r_em_alu_c[1:0]),
        .i_size  (r_em_mem_size),
        .i_uns   (r_em_mem_uns),
        .o_data  (w_load)
    );

    always_comb begin
        case (r_em_wb_sel)
            WB_MEM:  w_wD = w_load;
            WB_PC4:  w_wD = r_em_pc4;
            default: w_wD = r_em_alu_c;
        endcase
    end

    assign w_wb_valid = r_em_valid & ~w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_rf_we <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_wD    <= '0;
        end else begin
            r_wb_valid <= w_wb_valid;
            r_wb_rf_we <= w_wb_valid & r_em_rf_we & ~(w_memop & ~w_aligned);
            r_wb_rd    <= r_em_rd;
            r_wb_wD    <= w_wD;
        end
    end

    assign dm_req       = (r_state == ST_ACCESS);
    assign dm_we        = r_em_mem_wr;
    assign dm_addr      = {r_em_alu_c[XLEN-1:2], 2'b00};
    assign mem_stall    = w_stall;
    assign mem_misalign = w_memop & ~w_aligned;
    assign mem_alu_c    = r_em_alu_c;
    assign mem_rd       = r_em_rd;
    assign mem_rf_we    = r_em_rf_we & r_em_valid;
    assign wb_valid     = r_wb_valid;
    assign wb_rf_we     = r_wb_rf_we;
    assign wb_rd        = r_wb_rd;
    assign wb_wD        = r_wb_wD;
endmodule
